axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
- AXI-Lite responder (slave) front-end of the accelerator register map.
- Terminates AXI-Lite write and read transactions issued by the host/PS or by bench drivers.
- Converts them into a simple single-cycle register-bus write strobe and a variable-latency register-bus read request towards the regmap block inside dig_top_wrapp.
- Generates OKAY/SLVERR responses.

Parameters:
- C_S_AXI_ADDR_WDT, 16, AXI-Lite address width (byte address)
- C_S_AXI_DATA_WDT, 32, AXI-Lite data width
- C_S_AXI_STRB_WDT, C_S_AXI_DATA_WDT/8, write strobe width
- C_REG_SPACE, 16'h0400, byte size of decoded register space; addresses >= C_REG_SPACE are out of range
- C_RD_TIMEOUT, 64, read-wait timeout in cycles (used only with AXIL_RD_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WDT  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  C_S_AXI_DATA_WDT  write data
- S_AXI_WSTRB  in  C_S_AXI_STRB_WDT  write strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response (00 OKAY, 10 SLVERR)
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WDT  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  C_S_AXI_DATA_WDT  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- reg_wr_en  out  1  one-cycle register write strobe
- reg_wr_addr  out  C_S_AXI_ADDR_WDT-2  word address
- reg_wr_data  out  C_S_AXI_DATA_WDT  write data
- reg_wr_strb  out  C_S_AXI_STRB_WDT  byte enables
- reg_rd_en  out  1  one-cycle read request
- reg_rd_addr  out  C_S_AXI_ADDR_WDT-2  word address
- reg_rd_data  in  C_S_AXI_DATA_WDT  read data from register file
- reg_rd_valid  in  1  read data valid (>= 1 cycle after reg_rd_en)

Behaviour:

Reset (async, rst_n=0):
- All outputs 0, except AWREADY=WREADY=ARREADY=1.
- Both FSMs go to IDLE; latched address/data are cleared.
- Reset mid-transaction drops it silently; no response is issued.

Write FSM (W_IDLE -> W_EXEC -> W_RESP):
- AW and W accepted independently, in any order. Each ready deasserts the cycle after its own handshake and stays low until B completes.
- When both address and data are held (same or different edges), next state is W_EXEC.
- W_EXEC lasts one cycle. reg_wr_en=1 if AWADDR < C_REG_SPACE, otherwise no strobe.
- reg_wr_addr = AWADDR[ADDR_WDT-1:2]; low address bits are ignored.
- W_RESP: BVALID=1, BRESP=OKAY or SLVERR (out of range). Held stable until BREADY. The handshake edge returns to W_IDLE, where AWREADY and WREADY are reasserted.
- Minimum latency: AW+W together at edge N -> reg_wr_en in cycle N+1 -> BVALID from edge N+1.
- WSTRB=0 is still a strobe with reg_wr_strb=0 and an OKAY response.

Read FSM (R_IDLE -> R_REQ -> R_WAIT -> R_RESP):
- ARREADY=1 only in R_IDLE. Handshake latches the address.
- R_REQ: one cycle, reg_rd_en=1 (in range).
- R_WAIT: waits for reg_rd_valid, capturing reg_rd_data and RRESP=OKAY.
- Out of range: R_REQ goes straight to R_RESP with RDATA=0 and SLVERR, and no reg_rd_en.
- R_RESP: RVALID and RDATA held stable until RREADY, then return to R_IDLE.
- reg_rd_valid outside R_WAIT is ignored.

Concurrency:
- Read and write FSMs are fully independent.
- reg_wr_en and reg_rd_en may pulse in the same cycle, even to the same address. The register file returns the pre-write value.

Optional Feature:
Macro AXIL_RD_TIMEOUT_EN.
- Defined: a counter runs in R_WAIT. After C_RD_TIMEOUT cycles without reg_rd_valid, the FSM goes to R_RESP with RDATA=32'hDEAD_BEEF and RRESP=SLVERR. A late reg_rd_valid is ignored.
- Undefined: no counter; R_WAIT waits indefinitely.

Test Plan:
1. AW 0x0010 and W 0xA5A5_0001 (strb 0xF) same cycle, BREADY=1 -> reg_wr_en one cycle with addr 0x004, data 0xA5A5_0001; BVALID next cycle with BRESP=00.
2. W valid 3 cycles before AW, BREADY delayed 5 cycles -> single reg_wr_en after AW handshake; BVALID held 5 cycles; AWREADY/WREADY low until B handshake.
3. AR 0x0020, reg_rd_valid 4 cycles after reg_rd_en with data 0x1234_5678, RREADY held low 3 cycles -> RDATA 0x1234_5678 stable, RRESP=00, exactly one reg_rd_en.
4. Write to 0x0400 and read from 0x0800 -> no reg_wr_en, no reg_rd_en; BRESP=10; RRESP=10, RDATA=0.
5. rst_n low during R_WAIT and during W_RESP -> no RVALID/BVALID after release; ready signals back at 1; new write completes normally.
6. With AXIL_RD_TIMEOUT_EN, C_RD_TIMEOUT=64, reg_rd_valid never asserted -> RVALID after 64 wait cycles, RDATA=0xDEAD_BEEF, RRESP=10.

Source files
------------

// File: rtl/axil_reg_slave.sv
// axil_reg_slave
//   AXI-Lite responder in front of the accelerator register map. Each AXI-Lite
//   write becomes a single-cycle register-bus write strobe. Each AXI-Lite read
//   becomes a single-cycle read request, and the register file answers it with
//   reg_rd_valid after a variable latency. Addresses at or above C_REG_SPACE
//   produce no register-bus activity and return SLVERR.
//
// Optional feature (macro AXIL_RD_TIMEOUT_EN):
//   If reg_rd_valid does not arrive within C_RD_TIMEOUT cycles of waiting, the
//   read completes with RDATA = 32'hDEAD_BEEF and RRESP = SLVERR. A reg_rd_valid
//   that arrives after that is ignored. Without the macro the read waits forever.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   S_AXI_AW*/W*/B*       AXI-Lite write address, write data and write response
//   S_AXI_AR*/R*          AXI-Lite read address and read data
//   reg_wr_*              write strobe with word address, data and byte enables
//   reg_rd_en/addr        read request with word address
//   reg_rd_data/valid     read return from the register file

module axil_reg_slave #(
    parameter int unsigned C_S_AXI_ADDR_WDT = 16,
    parameter int unsigned C_S_AXI_DATA_WDT = 32,
    parameter int unsigned C_S_AXI_STRB_WDT = C_S_AXI_DATA_WDT / 8,
    parameter int unsigned C_REG_SPACE      = 32'h0000_0400,
    parameter int unsigned C_RD_TIMEOUT     = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // AXI-Lite write channels
    input  logic [C_S_AXI_ADDR_WDT-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WDT-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_STRB_WDT-1:0]   S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    // AXI-Lite read channels
    input  logic [C_S_AXI_ADDR_WDT-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WDT-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    // Register bus
    output logic                          reg_wr_en,
    output logic [C_S_AXI_ADDR_WDT-3:0]   reg_wr_addr,
    output logic [C_S_AXI_DATA_WDT-1:0]   reg_wr_data,
    output logic [C_S_AXI_STRB_WDT-1:0]   reg_wr_strb,
    output logic                          reg_rd_en,
    output logic [C_S_AXI_ADDR_WDT-3:0]   reg_rd_addr,
    input  logic [C_S_AXI_DATA_WDT-1:0]   reg_rd_data,
    input  logic                          reg_rd_valid
);

    localparam int unsigned AddrW = C_S_AXI_ADDR_WDT;
    localparam int unsigned DataW = C_S_AXI_DATA_WDT;
    localparam int unsigned StrbW = C_S_AXI_STRB_WDT;
    localparam logic [AddrW-1:0] RegSpace = AddrW'(C_REG_SPACE);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {WIdle, WExec, WResp} w_state_e;

    w_state_e               w_state_q, w_state_d;
    logic                   aw_held_q, aw_held_d;
    logic                   w_held_q, w_held_d;
    logic [AddrW-1:0]       awaddr_q, awaddr_d;
    logic [DataW-1:0]       wdata_q, wdata_d;
    logic [StrbW-1:0]       wstrb_q, wstrb_d;
    logic                   aw_hs, w_hs, wr_in_range;

    // Each ready drops after its own handshake and only returns in WIdle,
    // i.e. after the B handshake, since the held flags are cleared on exit.
    assign S_AXI_AWREADY = (w_state_q == WIdle) && !aw_held_q;
    assign S_AXI_WREADY  = (w_state_q == WIdle) && !w_held_q;
    assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
    assign wr_in_range   = awaddr_q < RegSpace;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        unique case (w_state_q)
            WIdle: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    w_state_d = WExec;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            WExec: w_state_d = WResp;
            WResp: begin
                if (S_AXI_BREADY) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    assign reg_wr_en    = (w_state_q == WExec) && wr_in_range;
    assign reg_wr_addr  = awaddr_q[AddrW-1:2];
    assign reg_wr_data  = wdata_q;
    assign reg_wr_strb  = wstrb_q;
    assign S_AXI_BVALID = (w_state_q == WResp);
    assign S_AXI_BRESP  = (S_AXI_BVALID && !wr_in_range) ? RespSlvErr : RespOkay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= WIdle;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RIdle, RReq, RWait, RResp} r_state_e;

    r_state_e               r_state_q, r_state_d;
    logic [AddrW-1:0]       araddr_q, araddr_d;
    logic [DataW-1:0]       rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic                   rd_in_range;

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int unsigned CntW = (C_RD_TIMEOUT > 1) ? $clog2(C_RD_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(C_RD_TIMEOUT - 1);
    logic [CntW-1:0]        cnt_q, cnt_d;
`endif

    assign S_AXI_ARREADY = (r_state_q == RIdle);
    assign rd_in_range   = araddr_q < RegSpace;

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
`ifdef AXIL_RD_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (r_state_q)
            RIdle: begin
                if (S_AXI_ARVALID) begin
                    araddr_d  = S_AXI_ARADDR;
                    r_state_d = RReq;
                end
            end
            RReq: begin
                if (rd_in_range) begin
                    r_state_d = RWait;
`ifdef AXIL_RD_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end else begin
                    rdata_d   = '0;
                    rresp_d   = RespSlvErr;
                    r_state_d = RResp;
                end
            end
            RWait: begin
                if (reg_rd_valid) begin
                    rdata_d   = reg_rd_data;
                    rresp_d   = RespOkay;
                    r_state_d = RResp;
                end
`ifdef AXIL_RD_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    rdata_d   = DataW'(32'hDEAD_BEEF);
                    rresp_d   = RespSlvErr;
                    r_state_d = RResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            RResp: begin
                if (S_AXI_RREADY) begin
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    assign reg_rd_en    = (r_state_q == RReq) && rd_in_range;
    assign reg_rd_addr  = araddr_q[AddrW-1:2];
    assign S_AXI_RVALID = (r_state_q == RResp);
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= RIdle;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
`ifdef AXIL_RD_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
`ifdef AXIL_RD_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Protection bits carry no meaning for this register map.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, 32'(C_RD_TIMEOUT)};

endmodule

// File: tb/tb_axil_reg_slave.sv
module tb_axil_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [15:0] S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        reg_wr_en;
    logic [13:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_rd_en;
    logic [13:0] reg_rd_addr;
    logic [31:0] reg_rd_data = 32'hBAD0_BAD0;
    logic        reg_rd_valid = 1'b0;

    axil_reg_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_data   (reg_rd_data),
        .reg_rd_valid  (reg_rd_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (spec-level) ----------------
    logic [31:0] exp_mem [256];

    function automatic bit in_range(input logic [15:0] a);
        return a < 16'h0400;
    endfunction

    function automatic logic [1:0] model_resp(input logic [15:0] a);
        return in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) exp_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        return in_range(a) ? exp_mem[a[9:2]] : 32'h0;
    endfunction

    // ---------------- register-file responder / monitor ----------------
    logic [31:0] mem [256];
    int          rd_delay = 1;  // 0 = never answer
    int          cyc = 0;
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    int          rd_cd = 0, rd_en_cyc = 0, rv_cyc = 0;
    logic        rd_pend = 1'b0, rv_prev = 1'b0;
    logic [31:0] rd_val = '0;
    logic [13:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [3:0]  last_wr_strb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_pend      <= 1'b0;
            reg_rd_valid <= 1'b0;
            reg_rd_data  <= 32'hBAD0_BAD0;
            rv_prev      <= 1'b0;
        end else begin
            reg_rd_valid <= 1'b0;
            reg_rd_data  <= 32'hBAD0_BAD0;
            if (rd_pend) begin
                if (rd_cd <= 1) begin
                    reg_rd_valid <= 1'b1;
                    reg_rd_data  <= rd_val;
                    rd_pend      <= 1'b0;
                end else begin
                    rd_cd <= rd_cd - 1;
                end
            end
            if (reg_rd_en) begin
                rd_cnt       <= rd_cnt + 1;
                rd_en_cyc    <= cyc;
                last_rd_addr <= reg_rd_addr;
                rd_val       <= mem[reg_rd_addr[7:0]];  // pre-write value
                if (rd_delay > 0) begin
                    rd_pend <= 1'b1;
                    rd_cd   <= rd_delay;
                end
            end
            if (reg_wr_en) begin
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= reg_wr_addr;
                last_wr_data <= reg_wr_data;
                last_wr_strb <= reg_wr_strb;
                for (int b = 0; b < 4; b++) begin
                    if (reg_wr_strb[b]) mem[reg_wr_addr[7:0]][8*b +: 8] <= reg_wr_data[8*b +: 8];
                end
            end
            if (reg_wr_en && reg_rd_en) both_cnt <= both_cnt + 1;
            if (S_AXI_RVALID && !rv_prev) rv_cyc <= cyc;
            rv_prev <= S_AXI_RVALID;
        end
    end

    // ---------------- AXI-Lite master tasks ----------------
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, input logic [1:0] exp_resp);
        int k = 0;
        fork
            begin
                int n = 0;
                repeat (aw_dly) @(negedge clk);
                S_AXI_AWADDR  = addr;
                S_AXI_AWVALID = 1'b1;
                while (!S_AXI_AWREADY && n < 300) begin @(negedge clk); n++; end
                if (!S_AXI_AWREADY) chk("aw_handshake_timeout", 0, 1);
                else begin @(posedge clk); #1; end
                S_AXI_AWVALID = 1'b0;
            end
            begin
                int n = 0;
                repeat (w_dly) @(negedge clk);
                S_AXI_WDATA  = data;
                S_AXI_WSTRB  = strb;
                S_AXI_WVALID = 1'b1;
                while (!S_AXI_WREADY && n < 300) begin @(negedge clk); n++; end
                if (!S_AXI_WREADY) chk("w_handshake_timeout", 0, 1);
                else begin @(posedge clk); #1; end
                S_AXI_WVALID = 1'b0;
            end
        join
        while (!S_AXI_BVALID && k < 300) begin @(negedge clk); k++; end
        if (!S_AXI_BVALID) begin
            chk("bvalid_timeout", 0, 1);
            return;
        end
        chk("bresp", S_AXI_BRESP, exp_resp);
        repeat (b_dly) begin
            @(negedge clk);
            chk("bvalid_hold", S_AXI_BVALID, 1);
            chk("bresp_hold", S_AXI_BRESP, exp_resp);
            chk("awready_low", S_AXI_AWREADY, 0);
            chk("wready_low", S_AXI_WREADY, 0);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
        chk("bvalid_clear", S_AXI_BVALID, 0);
        chk("awready_back", S_AXI_AWREADY, 1);
        chk("wready_back", S_AXI_WREADY, 1);
    endtask

    task automatic axi_read(input logic [15:0] addr, input int rready_dly,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int k = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && k < 300) begin @(negedge clk); k++; end
        if (!S_AXI_ARREADY) begin
            chk("ar_handshake_timeout", 0, 1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        k = 0;
        while (!S_AXI_RVALID && k < 300) begin @(negedge clk); k++; end
        if (!S_AXI_RVALID) begin
            chk("rvalid_timeout", 0, 1);
            return;
        end
        chk("rdata", S_AXI_RDATA, exp_data);
        chk("rresp", S_AXI_RRESP, exp_resp);
        repeat (rready_dly) begin
            @(negedge clk);
            chk("rvalid_hold", S_AXI_RVALID, 1);
            chk("rdata_hold", S_AXI_RDATA, exp_data);
            chk("arready_low", S_AXI_ARREADY, 0);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
        chk("rvalid_clear", S_AXI_RVALID, 0);
        chk("arready_back", S_AXI_ARREADY, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          d1;     // write: AW delay, read: register-file latency
        int          d2;     // write: W delay
        int          d3;     // write: BREADY delay, read: RREADY delay
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          en;     // register-bus strobe expected
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int w0, r0, b0;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;

        vecs[0]  = '{1'b1, 16'h0014, 32'hDEAD_0002, 4'hF, 3, 0, 5, 2'b00, 32'h0, 1'b1};
        vecs[1]  = '{1'b0, 16'h0020, 32'h0, 4'h0, 4, 0, 3, 2'b00, 32'h1234_5678, 1'b1};
        vecs[2]  = '{1'b0, 16'h0010, 32'h0, 4'h0, 1, 0, 0, 2'b00, 32'hA5A5_0001, 1'b1};
        vecs[3]  = '{1'b1, 16'h0013, 32'h0000_FF00, 4'h2, 0, 1, 0, 2'b00, 32'h0, 1'b1};
        vecs[4]  = '{1'b0, 16'h0012, 32'h0, 4'h0, 2, 0, 1, 2'b00, 32'hA5A5_FF01, 1'b1};
        vecs[5]  = '{1'b1, 16'h0400, 32'hFFFF_FFFF, 4'hF, 1, 0, 2, 2'b10, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 16'h0800, 32'h0, 4'h0, 1, 0, 2, 2'b10, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 16'h03FC, 32'hCAFE_F00D, 4'hF, 0, 2, 0, 2'b00, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 16'h03FF, 32'h0, 4'h0, 3, 0, 0, 2'b00, 32'hCAFE_F00D, 1'b1};
        vecs[9]  = '{1'b1, 16'h0020, 32'hFFFF_FFFF, 4'h0, 0, 0, 1, 2'b00, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 16'h0020, 32'h0, 4'h0, 1, 0, 0, 2'b00, 32'h1234_5678, 1'b1};
        vecs[11] = '{1'b0, 16'h0400, 32'h0, 4'h0, 1, 0, 1, 2'b10, 32'h0, 1'b0};

        for (int i = 0; i < 256; i++) begin
            mem[i]     = i * 32'h0101_0101;
            exp_mem[i] = i * 32'h0101_0101;
        end
        mem[8]     = 32'h1234_5678;
        exp_mem[8] = 32'h1234_5678;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_awready", S_AXI_AWREADY, 1);
        chk("rst_wready", S_AXI_WREADY, 1);
        chk("rst_arready", S_AXI_ARREADY, 1);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_wr_addr", reg_wr_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // AW and W in the same cycle, BREADY already high: exact latency
        w0 = wr_cnt;
        S_AXI_AWADDR = 16'h0010; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hA5A5_0001; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(negedge clk);
        chk("t1_wr_en", reg_wr_en, 1);
        chk("t1_wr_addr", reg_wr_addr, 14'h004);
        chk("t1_wr_data", reg_wr_data, 32'hA5A5_0001);
        chk("t1_wr_strb", reg_wr_strb, 4'hF);
        chk("t1_bvalid_early", S_AXI_BVALID, 0);
        chk("t1_awready_low", S_AXI_AWREADY, 0);
        @(negedge clk);
        chk("t1_wr_en_single", reg_wr_en, 0);
        chk("t1_bvalid", S_AXI_BVALID, 1);
        chk("t1_bresp", S_AXI_BRESP, 2'b00);
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
        chk("t1_bvalid_clear", S_AXI_BVALID, 0);
        chk("t1_awready_back", S_AXI_AWREADY, 1);
        chk("t1_wr_cnt", wr_cnt - w0, 1);
        model_write(16'h0010, 32'hA5A5_0001, 4'hF);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            w0 = wr_cnt;
            r0 = rd_cnt;
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].d1, vecs[i].d2,
                          vecs[i].d3, vecs[i].resp);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                chk($sformatf("v%0d_wr_cnt", i), wr_cnt - w0, vecs[i].en);
                chk($sformatf("v%0d_rd_cnt", i), rd_cnt - r0, 0);
                if (vecs[i].en) begin
                    chk($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].addr[15:2]);
                    chk($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].data);
                    chk($sformatf("v%0d_wr_strb", i), last_wr_strb, vecs[i].strb);
                end
            end else begin
                rd_delay = vecs[i].d1;
                axi_read(vecs[i].addr, vecs[i].d3, vecs[i].rdata, vecs[i].resp);
                chk($sformatf("v%0d_rd_cnt", i), rd_cnt - r0, vecs[i].en);
                chk($sformatf("v%0d_wr_cnt", i), wr_cnt - w0, 0);
                if (vecs[i].en) chk($sformatf("v%0d_rd_addr", i), last_rd_addr, vecs[i].addr[15:2]);
            end
        end

        // Write and read to the same address in the same cycle: pre-write value
        rd_delay = 1;
        b0 = both_cnt;
        d = model_read(16'h0030);
        fork
            axi_write(16'h0030, 32'h7777_8888, 4'hF, 0, 0, 0, 2'b00);
            axi_read(16'h0030, 0, d, 2'b00);
        join
        model_write(16'h0030, 32'h7777_8888, 4'hF);
        chk("same_cycle_strobes", both_cnt - b0, 1);
        axi_read(16'h0030, 0, model_read(16'h0030), 2'b00);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h0400, 16'hFFFF));
            else a = 16'($urandom_range(0, 16'h03FF));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            w0 = wr_cnt;
            r0 = rd_cnt;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), model_resp(a));
                model_write(a, d, s);
                chk("rnd_wr_cnt", wr_cnt - w0, in_range(a) ? 1 : 0);
            end else begin
                rd_delay = $urandom_range(1, 5);
                axi_read(a, $urandom_range(0, 3), model_read(a), model_resp(a));
                chk("rnd_rd_cnt", rd_cnt - r0, in_range(a) ? 1 : 0);
            end
        end

        // Reset while the read waits and the write holds its response
        rd_delay = 0;
        w0 = wr_cnt;
        @(negedge clk);
        S_AXI_ARADDR = 16'h0020; S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR = 16'h0008; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h1111_2222; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("prerst_bvalid", S_AXI_BVALID, 1);
        chk("prerst_arready", S_AXI_ARREADY, 0);
        chk("prerst_rvalid", S_AXI_RVALID, 0);
`ifndef AXIL_RD_TIMEOUT_EN
        repeat (80) @(negedge clk);
        chk("no_timeout_rvalid", S_AXI_RVALID, 0);
`endif
        rst_n = 1'b0;
        #1;
        chk("midrst_awready", S_AXI_AWREADY, 1);
        chk("midrst_wready", S_AXI_WREADY, 1);
        chk("midrst_arready", S_AXI_ARREADY, 1);
        chk("midrst_bvalid", S_AXI_BVALID, 0);
        chk("midrst_rdata", S_AXI_RDATA, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_bvalid", S_AXI_BVALID, 0);
            chk("postrst_rvalid", S_AXI_RVALID, 0);
        end
        chk("rst_wr_cnt", wr_cnt - w0, 1);
        model_write(16'h0008, 32'h1111_2222, 4'hF);
        rd_delay = 2;
        axi_write(16'h0008, 32'h5555_AAAA, 4'hC, 0, 1, 1, 2'b00);
        model_write(16'h0008, 32'h5555_AAAA, 4'hC);
        axi_read(16'h0008, 1, model_read(16'h0008), 2'b00);

`ifdef AXIL_RD_TIMEOUT_EN
        // Register file never answers: 64 wait cycles then DEAD_BEEF / SLVERR
        rd_delay = 0;
        axi_read(16'h0020, 1, 32'hDEAD_BEEF, 2'b10);
        chk("timeout_latency", rv_cyc - rd_en_cyc, 65);
        rd_delay = 1;
        axi_read(16'h0020, 0, model_read(16'h0020), 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
